tick_gen: RTL

Programmable multi-rate tick generator, next generation of the team's fixed 10 ms clock divider. Produces a base one-cycle tick every `div_cur` clock cycles plus `CASCADE` decade-cascaded ticks (÷10, ÷100, …). The divisor is run-time loadable without a rebuild. Sits between the board clock and the timer/display logic, which consume single-cycle enable strobes rather than derived clocks.

---
 rtl/tick_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tick_gen.sv
// tick_gen: programmable multi-rate tick generator.
//
// Emits a one-cycle base strobe tick[0] every div_cur enabled cycles and
// CASCADE decade strobes tick[k] every div_cur*10^k enabled cycles. All
// strobes of one wrap are coincident with tick[0]. The divisor can be
// reloaded at run time; a loaded value of 0 is treated as 1.
//
// Build option: define TICK_GEN_SHADOW_EN to defer divisor loads to the
// next base wrap through a shadow register (pend flags a waiting value).
// Without it a load takes effect on the next edge and restarts the base
// period, and pend is tied low.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   en        count enable; low freezes counters, ticks go low
//   clr       synchronous clear of all counters
//   div_load  one-cycle strobe to load div_val
//   div_val   new divisor
//   tick      [0] base strobe, [k] decade-k strobe
//   div_cur   divisor currently in effect
//   pend      shadow divisor waiting for the next wrap
module tick_gen #(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned DEFAULT_DIV = 1_000_000,
  parameter int unsigned CASCADE     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_val,
  output logic [CASCADE:0]   tick,
  output logic [CNT_W-1:0]   div_cur,
  output logic               pend
);

  localparam int unsigned DEC_W = 4;
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'(9);

  logic [CNT_W-1:0] cnt;
  logic [DEC_W-1:0] dec [1:CASCADE];
  logic [CASCADE:0] wrap_c;
  logic [CNT_W-1:0] load_val_c;

  // Divisor 0 would never wrap; clamp it to 1.
  assign load_val_c = (div_val == '0) ? CNT_W'(1) : div_val;

  // Wrap chain: stage k wraps when stage k-1 wraps and its decade is at 9.
  always_comb begin
    wrap_c    = '0;
    wrap_c[0] = en && (cnt == div_cur - CNT_W'(1));
    for (int k = 1; k <= int'(CASCADE); k++) begin
      wrap_c[k] = wrap_c[k-1] && (dec[k] == DEC_MAX);
    end
  end

  // Base counter, decade counters and tick strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= '0;
      for (int k = 1; k <= int'(CASCADE); k++) dec[k] <= '0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= '0;
      for (int k = 1; k <= int'(CASCADE); k++) dec[k] <= '0;
`ifndef TICK_GEN_SHADOW_EN
    end else if (div_load) begin
      // Immediate load restarts the base period; decades are kept.
      cnt  <= '0;
      tick <= '0;
`endif
    end else begin
      if (en) cnt <= wrap_c[0] ? '0 : cnt + CNT_W'(1);
      for (int k = 1; k <= int'(CASCADE); k++) begin
        if (wrap_c[k-1]) dec[k] <= wrap_c[k] ? '0 : dec[k] + DEC_W'(1);
      end
      // wrap_c is already gated by en, so ticks drop while frozen.
      tick <= wrap_c;
    end
  end

`ifdef TICK_GEN_SHADOW_EN
  logic [CNT_W-1:0] shadow;

  // Shadowed divisor: loads wait for the next base wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cur <= RST_DIV;
      shadow  <= RST_DIV;
      pend    <= 1'b0;
    end else if (clr) begin
      if (div_load)  div_cur <= load_val_c;
      else if (pend) div_cur <= shadow;
      pend <= 1'b0;
    end else if (div_load) begin
      // A load on the wrap edge itself is applied at that wrap.
      if (wrap_c[0]) begin
        div_cur <= load_val_c;
        pend    <= 1'b0;
      end else begin
        shadow  <= load_val_c;
        pend    <= 1'b1;
      end
    end else if (wrap_c[0] && pend) begin
      div_cur <= shadow;
      pend    <= 1'b0;
    end
  end
`else
  // Immediate divisor load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cur <= RST_DIV;
    end else if (div_load) begin
      div_cur <= load_val_c;
    end
  end

  assign pend = 1'b0;
`endif

endmodule
